// File: rtl/baud_pkg.sv
`default_nettype none
// ============================================================================
// Module      : baud_pkg
// Description : Standard baud-rate table and constant helpers (divisor,
//               phase increment, divider width) for baud_tick_gen.
// Revision    : 1.0
// ============================================================================
package baud_pkg;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned NUM_RATES          = 8;

    localparam int unsigned RATE_TABLE [NUM_RATES] = '{
        2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400
    };

    // Rounded clk / (os * rate).
    function automatic int unsigned baud_divisor(
        input int unsigned clk_hz,
        input int unsigned os,
        input int unsigned code
    );
        longint unsigned clk_l;
        longint unsigned den;
        clk_l = 64'(clk_hz);
        den   = 64'(os) * 64'(RATE_TABLE[code[2:0]]);
        return 32'((clk_l + den / 64'd2) / den);
    endfunction

    // Rounded os * rate * 2^acc_w / clk.
    function automatic longint unsigned baud_increment(
        input int unsigned clk_hz,
        input int unsigned os,
        input int unsigned acc_w,
        input int unsigned code
    );
        longint unsigned num;
        num = (64'(os) * 64'(RATE_TABLE[code[2:0]])) << acc_w;
        return (num + 64'(clk_hz) / 64'd2) / 64'(clk_hz);
    endfunction

    // Rate code 0 has the largest divisor, so it sets the counter width.
    function automatic int unsigned baud_cnt_width(
        input int unsigned clk_hz,
        input int unsigned os
    );
        int unsigned w;
        w = 32'($clog2(baud_divisor(clk_hz, os, 0)));
        return (w < 1) ? 1 : w;
    endfunction

endpackage : baud_pkg
`default_nettype wire

// File: rtl/baud_sample_div.sv
`default_nettype none
// ============================================================================
// Module      : baud_sample_div
// Description : Oversampling-strobe source. Integer divider by default;
//               ACC_W-bit phase accumulator when BAUD_FRAC_EN is defined.
// Revision    : 1.0
// ============================================================================
module baud_sample_div
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned ACC_W       = 24
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clear,
    input  logic [SEL_W-1:0] rate,
    output logic             sampleTick,
    output logic             wrap
);

    localparam int unsigned NUM_CODES = 1 << SEL_W;

    if (ACC_W < 8 || ACC_W > 40) begin : g_bad_acc_w
        $error("baud_sample_div: ACC_W out of range");
    end

    logic tick_q;

`ifdef BAUD_FRAC_EN
    logic [ACC_W-1:0] w_inc_tab [NUM_CODES];
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   w_sum;

    for (genvar g = 0; g < NUM_CODES; g++) begin : g_inc_tab
        assign w_inc_tab[g] = ACC_W'(baud_increment(CLK_FREQ_HZ, OVERSAMPLE, ACC_W, g));
    end

    // The carry out of the accumulator is the strobe request.
    assign w_sum = {1'b0, acc_q} + {1'b0, w_inc_tab[rate]};
    assign wrap  = ~clear & w_sum[ACC_W];
    assign acc_d = clear ? '0 : w_sum[ACC_W-1:0];

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    localparam int unsigned CNT_W = baud_cnt_width(CLK_FREQ_HZ, OVERSAMPLE);

    logic [CNT_W-1:0] w_last_tab [NUM_CODES];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    for (genvar g = 0; g < NUM_CODES; g++) begin : g_div_tab
        assign w_last_tab[g] = CNT_W'(baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, g) - 1);
    end

    assign wrap  = ~clear & (cnt_q == w_last_tab[rate]);
    assign cnt_d = (clear | wrap) ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap;
        end
    end

    assign sampleTick = tick_q;

endmodule : baud_sample_div
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Selectable-rate UART baud generator: oversampling strobe,
//               bit strobe and 50 % square wave. Define BAUD_FRAC_EN for the
//               phase-accumulator divider.
// Revision    : 1.0
// ============================================================================
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned ACC_W       = 24
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic [SEL_W-1:0] baudRate,
    output logic             sampleTick,
    output logic             baudTick,
    output logic             baudOut
);

    localparam int unsigned     OS_W       = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF_M1 = OS_W'(OVERSAMPLE / 2 - 1);

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("baud_tick_gen: OVERSAMPLE must be even and >= 4");
    end
    if (SEL_W != 2 && SEL_W != 3) begin : g_bad_sel_w
        $error("baud_tick_gen: SEL_W must be 2 or 3");
    end

    logic [SEL_W-1:0] rate_q;
    logic [OS_W-1:0]  os_q;
    logic [OS_W-1:0]  os_d;
    logic             baudTick_q;
    logic             baudTick_d;
    logic             baudOut_q;
    logic             baudOut_d;
    logic             w_clear;
    logic             w_wrap;

    // A rate change restarts timing exactly like a disabled cycle.
    assign w_clear = ~enable | (baudRate != rate_q);

    baud_sample_div #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .OVERSAMPLE  (OVERSAMPLE),
        .SEL_W       (SEL_W),
        .ACC_W       (ACC_W)
    ) u_sample_div (
        .clock      (clock),
        .rst        (rst),
        .clear      (w_clear),
        .rate       (rate_q),
        .sampleTick (sampleTick),
        .wrap       (w_wrap)
    );

    // Updated on the divider wrap so baudTick/baudOut align with sampleTick.
    always_comb begin
        os_d       = os_q;
        baudTick_d = 1'b0;
        baudOut_d  = baudOut_q;
        if (w_clear) begin
            os_d      = '0;
            baudOut_d = 1'b0;
        end else if (w_wrap) begin
            if (os_q == OS_LAST) begin
                os_d       = '0;
                baudTick_d = 1'b1;
                baudOut_d  = 1'b0;
            end else begin
                os_d = os_q + OS_W'(1);
                if (os_q == OS_HALF_M1) begin
                    baudOut_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rate_q     <= '0;
            os_q       <= '0;
            baudTick_q <= 1'b0;
            baudOut_q  <= 1'b0;
        end else begin
            rate_q     <= baudRate;
            os_q       <= os_d;
            baudTick_q <= baudTick_d;
            baudOut_q  <= baudOut_d;
        end
    end

    assign baudTick = baudTick_q;
    assign baudOut  = baudOut_q;

endmodule : baud_tick_gen
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_baud_tick_gen
// Description : Scoreboard bench for baud_tick_gen (50 MHz, OVERSAMPLE=16,
//               integer divider build) with a closed-form timing model.
// Revision    : 1.0
// ============================================================================
module tb_baud_tick_gen;

    localparam int OS = 16;
    localparam int D_TAB [8] = '{1302, 651, 326, 163, 81, 54, 27, 14};

    typedef struct {
        int         cyc;
        logic [2:0] val;   // {sampleTick, baudTick, baudOut}
    } ev_t;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] baudRate = 3'd0;
    logic       sampleTick;
    logic       baudTick;
    logic       baudOut;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   clr_cyc = -1;
    int   ref_rate = 0;
    logic [2:0] prev_exp = 3'b000;
    logic [2:0] prev_dut = 3'b000;
    ev_t  sb_q [$];

    always #5 clock = ~clock;

    baud_tick_gen dut (
        .clock      (clock),
        .rst        (rst),
        .enable     (enable),
        .baudRate   (baudRate),
        .sampleTick (sampleTick),
        .baudTick   (baudTick),
        .baudOut    (baudOut)
    );

    // Reference: outputs depend only on cycles elapsed since the last clear.
    task automatic model_step();
        int j;
        int n;
        int d;
        logic st;
        logic bt;
        logic bo;
        logic [2:0] exp_v;
        ev_t e;
        cyc++;
        if (!rst) begin
            clr_cyc  = cyc - 1;
            ref_rate = 0;
        end else begin
            if (!enable || int'(baudRate) != ref_rate) clr_cyc = cyc - 1;
            ref_rate = int'(baudRate);
        end
        j  = cyc - clr_cyc - 1;
        d  = D_TAB[ref_rate];
        n  = j / d;
        st = (j > 0) && (j % d == 0);
        bt = st && (n % OS == 0);
        bo = (n % OS) >= OS / 2;
        exp_v = rst ? {st, bt, bo} : 3'b000;
        if (rst && (exp_v != prev_exp || st)) begin
            e.cyc = cyc;
            e.val = exp_v;
            sb_q.push_back(e);
        end
        prev_exp = exp_v;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge rst);
            sb_q.delete();
            prev_exp = 3'b000;
        end
    end

    // Monitor: every output change or strobe must match the next expected event.
    initial begin
        logic [2:0] v;
        ev_t e;
        forever begin
            @(negedge clock);
            if (!rst) begin
                prev_dut = 3'b000;
            end else begin
                v = {sampleTick, baudTick, baudOut};
                while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                    e = sb_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_event got=none required=%b at cycle %0d (now %0d)",
                             e.val, e.cyc, cyc);
                end
                if (v != prev_dut || v[2]) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event got=%b at cycle %0d required=no change", v, cyc);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.cyc != cyc || e.val != v) begin
                            errors++;
                            $display("FAIL output_event got=%b at cycle %0d required=%b at cycle %0d",
                                     v, cyc, e.val, e.cyc);
                        end
                    end
                end
                prev_dut = v;
            end
        end
    end

    task automatic drive(input logic en, input logic [2:0] rate, input int cycles);
        @(posedge clock);
        #1;
        enable   = en;
        baudRate = rate;
        repeat (cycles - 1) @(posedge clock);
    endtask

    initial begin
        bit found;
        #12;
        checks++;
        if ({sampleTick, baudTick, baudOut} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state got=%b required=000", {sampleTick, baudTick, baudOut});
        end
        @(posedge clock);
        #3 rst = 1'b1;

        // Long run at 9600 covers full baudOut high/low phases.
        drive(1'b1, 3'd2, 11000);
        // Mid-count switch from the slowest to the fastest rate.
        drive(1'b1, 3'd0, 700);
        drive(1'b1, 3'd7, 300);
        // Enable dropped for 100 cycles mid-run.
        drive(1'b1, 3'd5, 2000);
        drive(1'b0, 3'd5, 100);
        drive(1'b1, 3'd5, 1000);
        drive(1'b1, 3'd6, 1000);

        for (int i = 0; i < 12; i++) begin
            drive(($urandom_range(0, 5) != 0), 3'($urandom_range(3, 7)),
                  int'($urandom_range(100, 2500)));
        end

        // Asynchronous reset while a strobe and baudOut are high.
        drive(1'b1, 3'd7, 1);
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clock);
            if (sampleTick && baudOut) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_pulse got=timeout required=sampleTick&baudOut high");
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({sampleTick, baudTick, baudOut} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got=%b required=000", {sampleTick, baudTick, baudOut});
        end
        @(posedge clock);
        @(posedge clock);
        #3 rst = 1'b1;
        repeat (600) @(posedge clock);

        drive(1'b1, 3'd3, 3000);
        drive(1'b0, 3'd3, 5);
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_baud_tick_gen
`default_nettype wire

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate generator for the UART transmitter and receiver. From the system clock it produces three outputs for one of eight selectable standard rates:
- a one-cycle oversampling strobe, used by the receiver for mid-bit sampling;
- a one-cycle bit strobe, used by the transmitter for bit timing;
- a 50 % duty baud square wave.

It replaces the fixed 4-rate BaudGen. Codes 0–3 keep the BaudGen rate mapping.

## Interface
- CLK_FREQ_HZ, 50_000_000: system clock frequency.
- OVERSAMPLE, 16: sample strobes per bit. Must be even and ≥4.
- SEL_W, 3: width of the rate select. Must be 2 or 3.
- ACC_W, 24: phase-accumulator width. Used only when BAUD_FRAC_EN is defined.

- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run when high. While low, all counters are cleared and all outputs are held low.
- baudRate  in  SEL_W  rate select: 0=2400, 1=4800, 2=9600, 3=19200, 4=38400, 5=57600, 6=115200, 7=230400 b/s.
- sampleTick  out  1  one-cycle pulse at OVERSAMPLE×rate.
- baudTick  out  1  one-cycle pulse at the rate. Coincides with every OVERSAMPLE-th sampleTick.
- baudOut  out  1  square wave at the rate.

## Operation
- Reset: all counters and the accumulator clear to 0; the rate register loads 0; sampleTick, baudTick and baudOut are 0.
- Integer divider (default build):
  - Divisor D = round(CLK_FREQ_HZ / (OVERSAMPLE×rate)).
  - The divider counter runs 0..D-1. When it wraps, sampleTick is registered high for one cycle.
  - The counter width is sized for the largest divisor (rate code 0).
- Oversample counter:
  - Counts sampleTicks 0..OVERSAMPLE-1.
  - baudOut is set on the sampleTick that brings the count to OVERSAMPLE/2.
  - On the tick that wraps the count to 0, baudOut clears and baudTick pulses.
- Rate change:
  - baudRate is registered every cycle.
  - When the new value differs from the registered one, the divider, accumulator and oversample counter clear and baudOut goes low.
  - No tick is issued in the change cycle. The new rate is timed from that cycle.
- enable low: identical to a rate-change clear, held for as long as enable is low. Counting resumes on the first cycle with enable high.
- Reset mid-operation: outputs go low immediately (asynchronous reset), including in the middle of a pulse.

## Timing
- The first sampleTick is high in the cycle following the D-th rising edge after enable is first seen high.
- Spacing of ticks:
  - sampleTick: exactly D cycles apart (integer build).
  - baudTick: OVERSAMPLE×D cycles apart.
- baudOut is high for (OVERSAMPLE/2)×D cycles and low for (OVERSAMPLE/2)×D cycles.
- All outputs are registered; there is no combinational path from input to output.
- At 50 MHz with OVERSAMPLE=16, the divisor D per rate code is: 1302, 651, 326, 163, 81, 54, 27, 14.

## Configuration
- BAUD_FRAC_EN defined:
  - The divider is replaced by an ACC_W-bit phase accumulator.
  - Increment = round(OVERSAMPLE×rate×2^ACC_W / CLK_FREQ_HZ).
  - sampleTick pulses on the cycle after the accumulator carries out.
  - Long-run rate error is below 1 ppm plus the rounding of the increment; individual tick spacing jitters by ±1 cycle.
- BAUD_FRAC_EN undefined: the integer divider is used, with a fixed period and the rounding error of D.
- All other behaviour is identical in both builds, including clear, enable, baudTick and baudOut.

## Structure
- Package baud_pkg holds:
  - the rate table as a constant array indexed by code;
  - constant functions for the divisor, the increment and the counter width (the width via $clog2 of the largest divisor);
  - the default OVERSAMPLE.
- Sub-module baud_sample_div contains the integer divider or the phase accumulator. Its interface is clock, rst, clear, rate code in, sampleTick out.
- The top level contains the rate register, the change detection, the oversample counter and baudOut.

## Test plan
- Rate code 2, enable=1, 50 MHz: sampleTick period is 326 cycles, baudTick period is 5216 cycles, and baudOut is high for 2608 cycles and low for 2608 cycles.
- Rate code 6 (115200): sampleTick period is 27 cycles. With BAUD_FRAC_EN, 1,000,000 cycles yield 36864±1 sampleTicks.
- Switch from rate code 0 to rate code 7 mid-count: counters clear in the change cycle, and the first new sampleTick arrives 14 cycles later. No runt pulse occurs.
- enable low for 100 cycles during a run: all outputs stay 0. After enable returns high, the first sampleTick arrives after D cycles.
- Assert rst mid-pulse: all outputs drop asynchronously. After release, the first-tick timing matches the post-reset case.
- Rate code 3 with SEL_W=2: sampleTick period is 163 cycles, matching the legacy 19.2 kb/s mapping.
